div_seq_ctrl: RTL and testbench

- Sequential controller for 32-bit unsigned restoring division.
- Sits directly upstream of the combinational ALU and drives its Src1, Src2 and Funct inputs.
- Uses Funct = 6'b000010 (conditional subtract). Each cycle it consumes ALU_result and ALU_Carry to build one quotient bit and the next partial remainder.
- Holds the dividend, divisor, partial remainder and quotient registers, and handles the start/done handshake with the issuing stage.

---
 rtl/div_seq_ctrl.sv | 163 ++++++++++++++++
 tb/tb_div_seq_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl.sv
// -----------------------------------------------------------------------------
// div_seq_ctrl
// Sequential controller for 32-bit unsigned restoring division. It drives the
// shared combinational ALU (Src1/Src2/Funct) and consumes ALU_result and
// ALU_Carry to produce one quotient bit per cycle over 32 iterations.
//
// Optional build macro: DIV_EARLY_OUT_EN
//   When defined, a request with a nonzero divisor larger than the dividend
//   completes in one cycle (quotient 0, remainder = dividend) without
//   iterating. When undefined, such requests take the normal 32-step path.
// -----------------------------------------------------------------------------
module div_seq_ctrl #(
    parameter logic [5:0] FUNCT_DIV = 6'b000010,
    parameter logic [5:0] FUNCT_NOP = 6'b000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic [31:0] alu_result,
    input  logic        alu_carry,
    output logic [31:0] alu_src1,
    output logic [31:0] alu_src2,
    output logic [5:0]  alu_funct,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] rem_r;          // partial remainder R
    logic [31:0] quo_r;          // dividend shifting out / quotient shifting in
    logic [31:0] dvs_r;          // latched divisor D
    logic [5:0]  cnt_r;          // iterations completed
    logic [31:0] quotient_r;
    logic [31:0] remainder_r;
    logic        dbz_r;

    logic [32:0] shift_s;        // {R, Q[31]}: remainder shifted left with next dividend bit
    logic        overflow_s;     // shifted remainder >= 2^32, subtract cannot borrow
    logic [31:0] local_diff_s;   // private subtractor used only in the overflow case
    logic [31:0] next_rem_s;
    logic [31:0] next_quo_s;
    logic        early_s;        // request resolvable without iterating

    // Next partial remainder and quotient for the current iteration.
    always_comb begin
        shift_s      = {rem_r, quo_r[31]};
        overflow_s   = shift_s[32];
        local_diff_s = shift_s[31:0] - dvs_r;
        if (overflow_s) begin
            // The ALU only sees 32 bits and would report a false borrow here,
            // so its result is ignored and the local subtractor is used.
            next_rem_s = local_diff_s;
            next_quo_s = {quo_r[30:0], 1'b1};
        end else begin
            next_rem_s = alu_result;
            next_quo_s = {quo_r[30:0], ~alu_carry};
        end
    end

    // Detect operands whose result is known at the accepting edge.
    always_comb begin
`ifdef DIV_EARLY_OUT_EN
        if (dividend < divisor) begin
            early_s = 1'b1;
        end else begin
            early_s = 1'b0;
        end
`else
        early_s = 1'b0;
`endif
    end

    // Control state, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            rem_r       <= 32'd0;
            quo_r       <= 32'd0;
            dvs_r       <= 32'd0;
            cnt_r       <= 6'd0;
            quotient_r  <= 32'd0;
            remainder_r <= 32'd0;
            dbz_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        if (divisor == 32'd0) begin
                            quotient_r  <= 32'hFFFF_FFFF;
                            remainder_r <= dividend;
                            dbz_r       <= 1'b1;
                            state_r     <= ST_DONE;
                        end else if (early_s) begin
                            quotient_r  <= 32'd0;
                            remainder_r <= dividend;
                            dbz_r       <= 1'b0;
                            state_r     <= ST_DONE;
                        end else begin
                            rem_r   <= 32'd0;
                            quo_r   <= dividend;
                            dvs_r   <= divisor;
                            cnt_r   <= 6'd0;
                            dbz_r   <= 1'b0;
                            state_r <= ST_BUSY;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    // start is deliberately not looked at here.
                    rem_r <= next_rem_s;
                    quo_r <= next_quo_s;
                    cnt_r <= cnt_r + 6'd1;
                    if (cnt_r == 6'd31) begin
                        quotient_r  <= next_quo_s;
                        remainder_r <= next_rem_s;
                        state_r     <= ST_DONE;
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // ALU operand/function drive, decoded from registered state only.
    always_comb begin
        if (state_r == ST_BUSY) begin
            alu_src1  = shift_s[31:0];
            alu_src2  = dvs_r;
            alu_funct = FUNCT_DIV;
        end else begin
            alu_src1  = 32'd0;
            alu_src2  = 32'd0;
            alu_funct = FUNCT_NOP;
        end
    end

    // Status and result outputs come straight from registers.
    always_comb begin
        busy        = (state_r == ST_BUSY);
        done        = (state_r == ST_DONE);
        quotient    = quotient_r;
        remainder   = remainder_r;
        div_by_zero = dbz_r;
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for div_seq_ctrl. Provides a behavioural ALU, a
// cycle-level reference model built from plain division, directed cases with
// literal expectations and a randomized operand sweep.
// -----------------------------------------------------------------------------
module tb_div_seq_ctrl;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] alu_result;
    logic        alu_carry;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [5:0]  alu_funct;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    div_seq_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .alu_src1   (alu_src1),
        .alu_src2   (alu_src2),
        .alu_funct  (alu_funct),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: conditional subtract keeps Src1 when the subtract borrows.
    always_comb begin
        if (alu_funct == 6'b000010) begin
            alu_carry  = (alu_src1 < alu_src2);
            alu_result = alu_carry ? alu_src1 : (alu_src1 - alu_src2);
        end else begin
            alu_carry  = 1'b0;
            alu_result = 32'd0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: only remembers how many busy cycles remain and what
    // the results must be, computed with / and %.
    int          m_left;
    logic [31:0] m_q, m_r, m_pq, m_pr, m_d;
    logic        m_dbz, m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_q <= 32'd0; m_r <= 32'd0; m_pq <= 32'd0; m_pr <= 32'd0; m_d <= 32'd0;
            m_dbz <= 1'b0; m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_q <= m_pq; m_r <= m_pr; m_done <= 1'b1;
                end
            end else if (start) begin
                if (divisor == 32'd0) begin
                    m_q <= 32'hFFFF_FFFF; m_r <= dividend; m_dbz <= 1'b1; m_done <= 1'b1;
                end else if (EARLY && (dividend < divisor)) begin
                    m_q <= 32'd0; m_r <= dividend; m_dbz <= 1'b0; m_done <= 1'b1;
                end else begin
                    m_pq <= dividend / divisor; m_pr <= dividend % divisor;
                    m_d <= divisor; m_left <= 32; m_dbz <= 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", {31'd0, busy}, {31'd0, (m_left != 0)});
            chk("done", {31'd0, done}, {31'd0, m_done});
            chk("quotient", quotient, m_q);
            chk("remainder", remainder, m_r);
            chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, m_dbz});
            chk("alu_funct", {26'd0, alu_funct}, (m_left != 0) ? 32'd2 : 32'd0);
            chk("alu_src2", alu_src2, (m_left != 0) ? m_d : 32'd0);
            if (m_left == 0) chk("alu_src1_idle", alu_src1, 32'd0);
        end
    end

    // Wait (bounded) for done; optionally inject one request or random noise while busy.
    task automatic wait_done(input bit noise, input int inject_at, output int lat, output int bc);
        lat = 1;
        bc  = 0;
        while (!done && lat < 100) begin
            if (busy) bc++;
            if (lat == inject_at) begin
                start = 1'b1; dividend = 32'd50; divisor = 32'd5;
            end else if (noise) begin
                start = 1'($urandom_range(0, 1)); dividend = $urandom; divisor = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic chk_result(input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                              input int elat, input int lat, input int bc);
        chk("done_seen", {31'd0, done}, 32'd1);
        chk("latency", lat, elat);
        chk("busy_cycles", bc, (elat == 33) ? 32'd32 : 32'd0);
        chk("res_quotient", quotient, eq);
        chk("res_remainder", remainder, er);
        chk("res_dbz", {31'd0, div_by_zero}, {31'd0, edbz});
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] eq,
                          input logic [31:0] er, input logic edbz, input int elat, input bit noise);
        int lat, bc;
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0;
        wait_done(noise, 0, lat, bc);
        chk_result(eq, er, edbz, elat, lat, bc);
    endtask

    task automatic check_all_zero();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        chk("rst_funct", {26'd0, alu_funct}, 32'd0);
    endtask

    initial begin
        int lat, bc;
        logic [31:0] a, b, eq, er;
        int elat;

        rst_n = 1'b0; start = 1'b0; dividend = 32'd0; divisor = 32'd0;
        #1 check_all_zero();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Basic and overflow-path divisions with literal expectations.
        run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 1'b0);
        run_op(32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0, 33, 1'b0);
        run_op(32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1, 1'b0);

        // Start while busy is ignored; start in the DONE cycle is accepted.
        @(negedge clk);
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0, 10, lat, bc);
        chk_result(32'd14, 32'd2, 1'b0, 33, lat, bc);
        start = 1'b1; dividend = 32'd50; divisor = 32'd5;
        @(negedge clk);
        start = 1'b0;
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        wait_done(1'b0, 0, lat, bc);
        chk_result(32'd10, 32'd0, 1'b0, 33, lat, bc);

        // Reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run_op(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33, 1'b0);

        // Dividend smaller than divisor.
        run_op(32'd5, 32'd9, 32'd0, 32'd5, 1'b0, EARLY ? 1 : 33, 1'b0);

        // Randomized operands, with random start noise while busy.
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = a + 32'd1;
                2: b = $urandom_range(1, 16);
                3: b = 32'd1;
                4: begin a = $urandom_range(0, 100); b = $urandom_range(1, 200); end
                5: b = 32'h8000_0000 | $urandom;
                default: b = $urandom;
            endcase
            eq   = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            er   = (b == 32'd0) ? a : a % b;
            elat = (b == 32'd0) ? 1 : ((EARLY && a < b) ? 1 : 33);
            run_op(a, b, eq, er, (b == 32'd0), elat, (i % 2) == 1);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
